// File: rtl/pos_cell_reader.sv
// Streams one cell of particle positions: reads the count word at address 0, then addresses 1..count
// through a credit-limited 4-entry output FIFO. Optional macro CELL_READER_COUNT_CLAMP_EN clamps the count.
module pos_cell_reader #(
  parameter int DATA_WIDTH   = 96,
  parameter int ADDR_WIDTH   = 8,
  parameter int PARTICLE_NUM = 220
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rden,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic [ADDR_WIDTH-1:0] particle_count,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_id,
  output logic                  out_last,
  output logic                  count_err
);

  localparam logic [ADDR_WIDTH-1:0] MAX_CNT = ADDR_WIDTH'(PARTICLE_NUM - 1);

  typedef enum logic [2:0] {IDLE, RD_CNT, WAIT_CNT, STREAM, DRAIN, FIN} state_t;

  state_t                state;
  logic [1:0]            wait_cnt;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  cnt_err_r;
  logic [ADDR_WIDTH-1:0] cnt_used;
  logic                  cnt_over;

  logic                  vld_p1, vld_p2;
  logic [ADDR_WIDTH-1:0] addr_p1, addr_p2;

  logic [DATA_WIDTH-1:0] fifo_data [4];
  logic [ADDR_WIDTH-1:0] fifo_id   [4];
  logic [1:0]            wr_ptr, rd_ptr;
  logic [2:0]            occ;
  logic [2:0]            pending;
  logic                  fifo_empty, issue, push, pop, fifo_wr, fifo_rd;

`ifdef CELL_READER_COUNT_CLAMP_EN
  assign cnt_over  = mem_q[ADDR_WIDTH-1:0] > MAX_CNT;
  assign cnt_used  = cnt_over ? MAX_CNT : mem_q[ADDR_WIDTH-1:0];
  assign count_err = cnt_err_r;
`else
  logic unused_cfg;
  assign cnt_over   = 1'b0;
  assign cnt_used   = mem_q[ADDR_WIDTH-1:0];
  assign count_err  = 1'b0;
  assign unused_cfg = ^{cnt_err_r, MAX_CNT};
`endif

  // Credit: every issued word already owns a FIFO slot, so the FIFO can never overflow.
  assign pending    = occ + {2'b00, vld_p1} + {2'b00, vld_p2};
  assign issue      = (state == STREAM) && (pending < 3'd4);
  assign mem_rden   = (state == RD_CNT) || issue;
  assign mem_addr   = issue ? rd_addr : '0;

  assign fifo_empty = (occ == 3'd0);
  assign push       = vld_p2;
  assign out_valid  = !fifo_empty || vld_p2;
  assign pop        = out_valid && out_ready;
  assign fifo_wr    = push && !(fifo_empty && pop);
  assign fifo_rd    = pop && !fifo_empty;

  // An empty FIFO passes the returning word straight through so streaming has no extra fill cycle.
  assign out_data = !fifo_empty ? fifo_data[rd_ptr] : (vld_p2 ? mem_q : '0);
  assign out_id   = !fifo_empty ? fifo_id[rd_ptr]   : (vld_p2 ? addr_p2 : '0);
  assign out_last = out_valid && (out_id == particle_count);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      wait_cnt       <= 2'd0;
      rd_addr        <= '0;
      particle_count <= '0;
      cnt_err_r      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state     <= RD_CNT;
          busy      <= 1'b1;
          cnt_err_r <= 1'b0;
        end
        RD_CNT: begin
          state    <= WAIT_CNT;
          wait_cnt <= 2'd0;
        end
        WAIT_CNT: begin
          wait_cnt <= wait_cnt + 2'd1;
          if (wait_cnt == 2'd1) begin
            particle_count <= cnt_used;
            cnt_err_r      <= cnt_over;
            rd_addr        <= ADDR_WIDTH'(1);
            if (cnt_used != '0) state <= STREAM;
          end else if (wait_cnt == 2'd2) begin
            // Empty cell: one settle cycle after the latch, then finish.
            state <= FIN;
            done  <= 1'b1;
          end
        end
        STREAM: if (issue) begin
          rd_addr <= rd_addr + ADDR_WIDTH'(1);
          if (rd_addr == particle_count) state <= DRAIN;
        end
        DRAIN: if (pop && out_last) begin
          state <= FIN;
          done  <= 1'b1;
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read return pipeline: p1 = issued last cycle, p2 = data on mem_q now.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      occ    <= 3'd0;
    end else begin
      vld_p1 <= issue;
      vld_p2 <= vld_p1;
      if (fifo_wr) wr_ptr <= wr_ptr + 2'd1;
      if (fifo_rd) rd_ptr <= rd_ptr + 2'd1;
      occ <= occ + {2'b00, push} - {2'b00, pop};
    end
  end

  always_ff @(posedge clk) begin
    addr_p1 <= rd_addr;
    addr_p2 <= addr_p1;
    if (fifo_wr) begin
      fifo_data[wr_ptr] <= mem_q;
      fifo_id[wr_ptr]   <= addr_p2;
    end
  end

endmodule

// File: doc/pos_cell_reader.md
POS_CELL_READER -- requirements
Module: pos_cell_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 96, width of one cell-memory word ({posz, posy, posx}).
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, cell-memory address width.
REQ-003 SHALL have parameter PARTICLE_NUM, default 220, number of words in the cell memory.
REQ-004 SHALL use one clock and an asynchronous, active-high reset: clk, in, 1, rising-edge clock for all state.
REQ-005 rst, in, 1, asynchronous, active-high reset.
REQ-006 start, in, 1, one-cycle request to read out the whole cell.
REQ-007 busy, out, 1, high from the accepted start until the done cycle.
REQ-008 done, out, 1, one-cycle pulse after the last particle is accepted downstream.
REQ-009 mem_addr, out, ADDR_WIDTH, cell-memory address.
REQ-010 mem_rden, out, 1, cell-memory read enable.
REQ-011 mem_q, in, DATA_WIDTH, cell-memory read data, valid 2 cycles after mem_rden.
REQ-012 particle_count, out, ADDR_WIDTH, count latched from address 0.
REQ-013 out_valid, out, 1, a particle word is presented downstream.
REQ-014 out_ready, in, 1, downstream accepts the word.
REQ-015 out_data, out, DATA_WIDTH, particle position.
REQ-016 out_id, out, ADDR_WIDTH, memory address of the presented particle (1..count).
REQ-017 out_last, out, 1, the presented particle is the final one.
REQ-018 count_err, out, 1, sticky flag for an oversized count (see Configuration).

Function
REQ-019 SHALL implement the states IDLE, RD_CNT, WAIT_CNT, STREAM, DRAIN and FIN.
REQ-020 IDLE: when start=1, go to RD_CNT; start in any other state SHALL be ignored.
REQ-021 RD_CNT: drive mem_addr=0 and mem_rden=1 for one cycle, then go to WAIT_CNT.
REQ-022 WAIT_CNT: exactly 2 cycles after the RD_CNT read, latch particle_count=mem_q[ADDR_WIDTH-1:0].
REQ-023 After the WAIT_CNT latch, go to FIN if the count is 0, otherwise go to STREAM.
REQ-024 STREAM: issue reads to addresses 1..count in ascending order, at most one read per cycle.
REQ-025 A read SHALL be issued only if (reads in flight + output FIFO occupancy) < 4.
REQ-026 Return data SHALL enter a 4-entry output FIFO, tagged with its address, exactly 2 cycles after issue.
REQ-027 The FIFO SHALL never overflow; data SHALL never be dropped or duplicated under any out_ready pattern.
REQ-028 After the read of address count is issued, go to DRAIN.
REQ-029 DRAIN: when the entry with out_last=1 is accepted (out_valid & out_ready), go to FIN.
REQ-030 out_valid SHALL be high whenever the FIFO is non-empty.
REQ-031 out_data, out_id and out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-032 A FIFO write and read in the same cycle SHALL leave occupancy unchanged.
REQ-033 out_last SHALL be high only on the entry whose out_id equals count.
REQ-034 FIN: assert done for one cycle, then go to IDLE.
REQ-035 busy SHALL be high in every state except IDLE, including the FIN cycle.
REQ-036 With full throughput (out_ready=1 continuously), SHALL present one particle per cycle after a 2-cycle fill.
REQ-037 Total latency from start to done for count N with out_ready=1 SHALL be N+6 cycles.
REQ-038 mem_rden SHALL be 0 in every cycle in which no read is issued; mem_addr is don't-care in those cycles.
REQ-039 particle_count SHALL hold its value until the next accepted start.

Reset
REQ-040 While rst=1: state=IDLE, FIFO and in-flight tracking cleared, and all outputs 0 (busy, done, mem_rden, mem_addr, out_*, particle_count, count_err).
REQ-041 Reset mid-operation SHALL abandon the transfer; reads still in flight SHALL be discarded after reset release.

Configuration
REQ-042 Macro CELL_READER_COUNT_CLAMP_EN. When defined:
- a latched count > PARTICLE_NUM-1 SHALL be replaced by PARTICLE_NUM-1;
- count_err SHALL be set and held until rst or the next accepted start.
When not defined:
- the count SHALL be used unmodified;
- count_err SHALL be tied to 0.

Verification
REQ-043 count=3, out_ready=1: start -> ids 1,2,3 on consecutive cycles, out_last on id 3, done at cycle 9 after start.
REQ-044 count=0: start -> no out_valid, done 5 cycles after start, particle_count=0.
REQ-045 count=10, out_ready toggling 1,0,0,1…: each of ids 1..10 is delivered exactly once, in order, with data equal to memory contents; reads in flight + FIFO occupancy never exceed 4.
REQ-046 start pulsed again during STREAM -> ignored; a single done is produced; a later start in IDLE runs correctly.
REQ-047 rst asserted during STREAM with count=8 -> all outputs 0 immediately; a subsequent start reads the count afresh with no stale data out.
REQ-048 With the macro defined, count=250 and PARTICLE_NUM=220 -> particle_count=219, count_err=1, ids 1..219 streamed.
